multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 8-bit microprocessor datapath. It replaces the single-cycle `Control` decode with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the existing `sig*` control lines plus instruction-register and PC write enables. It also retires instructions into a counter and stops the core on a detected infinite loop.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; forces the FSM to IDLE.
- `run`  in  1  start/continue enable; sampled in IDLE and at retire.
- `op`  in  2  opcode from the instruction register (bits 7:6); must be stable from DECODE until retire.
- `loopFlag`  in  1  PC-counter infinite-loop flag.
- `ovfFlag`  in  1  ALU overflow flag.
- `sigIRWrite`, `sigPCWrite`, `sigBranch`, `sigMemRead`, `sigMemWrite`, `sigMemtoReg`, `sigALUOp`, `sigALUSrc`, `sigRegWrite`, `sigRegDst`  out  1 each  datapath controls.
- `state`  out  3  current FSM state.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retireCount`  out  8  completed-instruction count.
- `halted`  out  1  high while in HALT.

## Operation
- Opcodes:
  - `00` ADD (R-type, destination = instr[1:0])
  - `01` LW
  - `10` SW
  - `11` J (relative branch)
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE on the next edge.
- IDLE: all controls are 0. If `run`=1, go to FETCH.
- FETCH: `sigIRWrite`=1. Go to DECODE.
- DECODE:
  - op=11: assert `sigBranch`=1 and `sigPCWrite`=1. If `loopFlag`=1, go to HALT with no retire. Otherwise retire.
  - Any other op: go to EXEC.
- EXEC:
  - op=00: `sigALUOp`=1, `sigALUSrc`=0. Go to WB.
  - op=01/10: `sigALUOp`=0, `sigALUSrc`=1 (address calculation). Go to MEM.
- MEM:
  - op=01: `sigMemRead`=1 (ALU controls held). Go to WB.
  - op=10: `sigMemWrite`=1, `sigPCWrite`=1. Retire.
- WB: `sigRegWrite`=1 and `sigPCWrite`=1.
  - op=00: `sigRegDst`=1, `sigALUOp`=1 held.
  - op=01: `sigMemtoReg`=1, `sigRegDst`=0.
  - Retire.
- Retire:
  - `retire`=1 for that cycle and `retireCount` increments (wraps 255→0).
  - Next state is FETCH if `run`=1, otherwise IDLE.
- HALT is sticky: all controls are 0 and `halted`=1. Only `reset` exits HALT.
- Controls not listed for a state are 0. Controls are a combinational function of the `state` register and `op`; there are no glitch paths from `run`, `loopFlag` or `ovfFlag` except as listed for DECODE and EXEC.

## Timing
- Reset values: `state`=IDLE, `retireCount`=0, `halted`=0, `retire`=0, all `sig*`=0. Outputs reach these values immediately on reset assertion, not at the next edge.
- Latency from FETCH entry to the retire cycle, inclusive: J = 2 cycles, ADD = 4, SW = 4, LW = 5.
- Back-to-back instructions: the cycle after retire is FETCH, so there are no bubble cycles.
- `run` deasserted mid-instruction: the current instruction completes, then the FSM enters IDLE.
- Reset mid-instruction:
  - Any pending write enable drops asynchronously.
  - The partially executed instruction does not retire.
  - `retireCount` clears.
- `loopFlag` is ignored outside DECODE with op=11.

## Configuration
- `MC_HALT_ON_OVF_EN` defined: `ovfFlag`=1 sampled in EXEC with op=00 sends the FSM to HALT. WB is skipped, so no register write, no PC write and no retire occur.
- `MC_HALT_ON_OVF_EN` undefined: `ovfFlag` is ignored and ADD always completes.

## Structure
- Shared package `mc_pkg` holds:
  - the state type and its encodings IDLE..HALT;
  - opcode constants `OP_ADD`, `OP_LW`, `OP_SW`, `OP_J`;
  - the state width constant.
- Sub-module `mc_decode` is a purely combinational (state, op) → control-vector decoder. The top level holds the state register, next-state logic, retire counter and halt logic.

## Test plan
- Reset, then `run`=1, ADD (op=00): states 0→1→2→3→5→1. `sigRegWrite`=`sigRegDst`=1 only in WB. `retireCount`=1 after 4 cycles.
- LW then SW back-to-back: LW shows `sigMemRead` in MEM and `sigMemtoReg`+`sigRegWrite` in WB, total 5 cycles. SW shows `sigMemWrite`+`sigPCWrite` in MEM, 4 cycles. `retireCount`=2.
- J with `loopFlag`=1 in DECODE: `sigBranch`=1 for one cycle, then `state`=6 and `halted`=1. `run` toggling afterwards has no effect. Reset returns `state`=0.
- Drop `run` during EXEC of an ADD: WB completes, `retire` pulses, then `state`=0 and all controls are 0.
- Assert `reset` during WB: `sigRegWrite` drops the same cycle and `retireCount`=0. Separately, 256 retires wrap `retireCount` to 0.
- With `MC_HALT_ON_OVF_EN` defined, ADD with `ovfFlag`=1 in EXEC gives HALT and no `sigRegWrite`. With the macro undefined, the same stimulus retires normally.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned COUNT_W = 8;

    // FSM states; encoding 7 is unused and recovers to IDLE
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } stateT;

    // Opcodes carried in instr[7:6]
    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_LW  = 2'b01;
    localparam logic [OP_W-1:0] OP_SW  = 2'b10;
    localparam logic [OP_W-1:0] OP_J   = 2'b11;

    // Datapath control vector produced by the decoder
    typedef struct packed {
        logic irWrite;
        logic pcWrite;
        logic branch;
        logic memRead;
        logic memWrite;
        logic memtoReg;
        logic aluOp;
        logic aluSrc;
        logic regWrite;
        logic regDst;
    } ctrlT;

endpackage

// File: rtl/mc_decode.sv
// Combinational (state, op) -> datapath control decoder for the multi-cycle core.
module mc_decode
    import mc_pkg::*;
(
    input  stateT            curState,
    input  logic [OP_W-1:0]  op,
    output ctrlT             ctrl
);

    // Moore-style control decode; every control not named for a state stays 0
    always_comb begin
        ctrl = '0;
        case (curState)
            FETCH: begin
                ctrl.irWrite = 1'b1;
            end
            DECODE: begin
                if (op == OP_J) begin
                    ctrl.branch  = 1'b1;
                    ctrl.pcWrite = 1'b1;
                end
            end
            EXEC: begin
                if (op == OP_ADD) begin
                    ctrl.aluOp = 1'b1;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    // address calculation: base + immediate
                    ctrl.aluSrc = 1'b1;
                end
            end
            MEM: begin
                if (op == OP_LW) begin
                    ctrl.memRead = 1'b1;
                    ctrl.aluSrc  = 1'b1;
                end else if (op == OP_SW) begin
                    ctrl.memWrite = 1'b1;
                    ctrl.pcWrite  = 1'b1;
                end
            end
            WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.pcWrite  = 1'b1;
                if (op == OP_ADD) begin
                    ctrl.regDst = 1'b1;
                    ctrl.aluOp  = 1'b1;
                end else if (op == OP_LW) begin
                    ctrl.memtoReg = 1'b1;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: state register, next-state logic,
// retire counter and halt detection. Optional feature macro:
// MC_HALT_ON_OVF_EN -- halt on ALU overflow during an ADD execute step.
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [1:0]  op,
    input  logic        loopFlag,
    input  logic        ovfFlag,
    output logic        sigIRWrite,
    output logic        sigPCWrite,
    output logic        sigBranch,
    output logic        sigMemRead,
    output logic        sigMemWrite,
    output logic        sigMemtoReg,
    output logic        sigALUOp,
    output logic        sigALUSrc,
    output logic        sigRegWrite,
    output logic        sigRegDst,
    output logic [2:0]  state,
    output logic        retire,
    output logic [7:0]  retireCount,
    output logic        halted
);

    stateT               curState;
    stateT               nextState;
    ctrlT                ctrl;
    logic                retireC;
    logic                ovfHalt;
    logic [COUNT_W-1:0]  countQ;

`ifdef MC_HALT_ON_OVF_EN
    assign ovfHalt = ovfFlag;
`else
    logic unusedOvf;
    assign unusedOvf = ovfFlag;
    assign ovfHalt   = 1'b0;
`endif

    // Control decode from the state register and the held opcode
    mc_decode uDecode (
        .curState (curState),
        .op       (op),
        .ctrl     (ctrl)
    );

    // Next-state and retire decision
    always_comb begin
        nextState = curState;
        retireC   = 1'b0;
        case (curState)
            IDLE: begin
                if (run) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                nextState = DECODE;
            end
            DECODE: begin
                if (op == OP_J) begin
                    // a branch to itself is an infinite loop: stop the core
                    if (loopFlag) begin
                        nextState = HALT;
                    end else begin
                        retireC = 1'b1;
                    end
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_ADD) begin
                    nextState = ovfHalt ? HALT : WB;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    nextState = MEM;
                end else begin
                    nextState = IDLE;
                end
            end
            MEM: begin
                if (op == OP_LW) begin
                    nextState = WB;
                end else if (op == OP_SW) begin
                    retireC = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            WB: begin
                retireC = 1'b1;
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        // retiring steps straight into the next fetch, or parks in IDLE
        if (retireC) begin
            nextState = run ? FETCH : IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    // Completed-instruction counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countQ <= '0;
        end else if (retireC) begin
            countQ <= COUNT_W'(countQ + 1'b1);
        end
    end

    // Output mapping
    always_comb begin
        sigIRWrite  = ctrl.irWrite;
        sigPCWrite  = ctrl.pcWrite;
        sigBranch   = ctrl.branch;
        sigMemRead  = ctrl.memRead;
        sigMemWrite = ctrl.memWrite;
        sigMemtoReg = ctrl.memtoReg;
        sigALUOp    = ctrl.aluOp;
        sigALUSrc   = ctrl.aluSrc;
        sigRegWrite = ctrl.regWrite;
        sigRegDst   = ctrl.regDst;
        state       = curState;
        retire      = retireC;
        retireCount = countQ;
        halted      = (curState == HALT);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model plus directed checks.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [1:0] op = 2'b00;
    logic       loopFlag = 1'b0;
    logic       ovfFlag = 1'b0;

    logic       sigIRWrite, sigPCWrite, sigBranch, sigMemRead, sigMemWrite;
    logic       sigMemtoReg, sigALUOp, sigALUSrc, sigRegWrite, sigRegDst;
    logic [2:0] state;
    logic       retire;
    logic [7:0] retireCount;
    logic       halted;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    // control bit weights, order {IRW,PCW,BR,MR,MW,M2R,ALUOP,ALUSRC,RW,RD}
    localparam logic [9:0] IRW    = 10'b1000000000;
    localparam logic [9:0] PCW    = 10'b0100000000;
    localparam logic [9:0] BR     = 10'b0010000000;
    localparam logic [9:0] MR     = 10'b0001000000;
    localparam logic [9:0] MW     = 10'b0000100000;
    localparam logic [9:0] M2R    = 10'b0000010000;
    localparam logic [9:0] ALUOP  = 10'b0000001000;
    localparam logic [9:0] ALUSRC = 10'b0000000100;
    localparam logic [9:0] RW     = 10'b0000000010;
    localparam logic [9:0] RD     = 10'b0000000001;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .op          (op),
        .loopFlag    (loopFlag),
        .ovfFlag     (ovfFlag),
        .sigIRWrite  (sigIRWrite),
        .sigPCWrite  (sigPCWrite),
        .sigBranch   (sigBranch),
        .sigMemRead  (sigMemRead),
        .sigMemWrite (sigMemWrite),
        .sigMemtoReg (sigMemtoReg),
        .sigALUOp    (sigALUOp),
        .sigALUSrc   (sigALUSrc),
        .sigRegWrite (sigRegWrite),
        .sigRegDst   (sigRegDst),
        .state       (state),
        .retire      (retire),
        .retireCount (retireCount),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // Each instruction is a list of cycles starting at fetch.
    function automatic int seqLen(input logic [1:0] o);
        case (o)
            2'b00:   return 4;
            2'b01:   return 5;
            2'b10:   return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] seqState(input logic [1:0] o, input int s);
        logic [2:0] t [5];
        case (o)
            2'b00:   t = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
            2'b01:   t = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
            2'b10:   t = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
            default: t = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
        endcase
        return t[s[2:0]];
    endfunction

    function automatic logic [9:0] seqCtl(input logic [1:0] o, input int s);
        logic [9:0] t [5];
        case (o)
            2'b00:   t = '{IRW, 10'd0, ALUOP, RW | PCW | RD | ALUOP, 10'd0};
            2'b01:   t = '{IRW, 10'd0, ALUSRC, MR | ALUSRC, RW | PCW | M2R};
            2'b10:   t = '{IRW, 10'd0, ALUSRC, MW | PCW, 10'd0};
            default: t = '{IRW, BR | PCW, 10'd0, 10'd0, 10'd0};
        endcase
        return t[s[2:0]];
    endfunction

    int         mMode = 0;   // 0 idle, 1 running, 2 halted
    int         mStep = 0;
    logic [7:0] mCnt  = 8'd0;

    function automatic bit ovfHaltNow();
`ifdef MC_HALT_ON_OVF_EN
        return (op == 2'b00) && (mStep == 2) && ovfFlag;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit expRetire();
        return (mMode == 1) && (mStep == seqLen(op) - 1) && !((op == 2'b11) && loopFlag);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mMode = 0;
            mStep = 0;
            mCnt  = 8'd0;
        end else begin
            case (mMode)
                0: if (run) begin
                    mMode = 1;
                    mStep = 0;
                end
                1: begin
                    if ((op == 2'b11) && (mStep == 1) && loopFlag) begin
                        mMode = 2;
                    end else if (ovfHaltNow()) begin
                        mMode = 2;
                    end else if (mStep == seqLen(op) - 1) begin
                        mCnt = mCnt + 8'd1;
                        if (run) mStep = 0;
                        else     mMode = 0;
                    end else begin
                        mStep = mStep + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        logic [2:0] eState;
        logic [9:0] eCtl;
        logic [9:0] aCtl;
        if (checkOn) begin
            eState = (mMode == 1) ? seqState(op, mStep) : ((mMode == 2) ? 3'd6 : 3'd0);
            eCtl   = (mMode == 1) ? seqCtl(op, mStep) : 10'd0;
            aCtl   = {sigIRWrite, sigPCWrite, sigBranch, sigMemRead, sigMemWrite,
                      sigMemtoReg, sigALUOp, sigALUSrc, sigRegWrite, sigRegDst};
            check("model.state", 32'(state), 32'(eState));
            check("model.ctl", 32'(aCtl), 32'(eCtl));
            check("model.retire", 32'(retire), 32'(expRetire()));
            check("model.count", 32'(retireCount), 32'(mCnt));
            check("model.halted", 32'(halted), 32'(mMode == 2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        step();
        step();
        checkOn = 1'b1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.count", 32'(retireCount), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.pcw", 32'(sigPCWrite), 32'd0);

        // ADD: 0 -> 1 -> 2 -> 3 -> 5 -> 1
        reset = 1'b0; run = 1'b1; op = 2'b00;
        step(); check("add.s1", 32'(state), 32'd1); check("add.irw", 32'(sigIRWrite), 32'd1);
        step(); check("add.s2", 32'(state), 32'd2);
        step(); check("add.s3", 32'(state), 32'd3); check("add.aluop", 32'(sigALUOp), 32'd1);
        step(); check("add.s5", 32'(state), 32'd5);
        check("add.rwrd", 32'({sigRegWrite, sigRegDst}), 32'd3);
        check("add.retire", 32'(retire), 32'd1);
        step(); check("add.next", 32'(state), 32'd1); check("add.count", 32'(retireCount), 32'd1);

        // LW back-to-back with SW
        op = 2'b01;
        step(); step(); check("lw.alusrc", 32'(sigALUSrc), 32'd1);
        step(); check("lw.s4", 32'(state), 32'd4); check("lw.memread", 32'(sigMemRead), 32'd1);
        step(); check("lw.wb", 32'({sigMemtoReg, sigRegWrite, sigRegDst}), 32'd6);
        check("lw.retire", 32'(retire), 32'd1);
        step(); check("lw.count", 32'(retireCount), 32'd2);
        op = 2'b10;
        step(); step();
        step(); check("sw.mem", 32'({sigMemWrite, sigPCWrite, sigRegWrite}), 32'd6);
        check("sw.retire", 32'(retire), 32'd1);
        step(); check("sw.next", 32'(state), 32'd1); check("sw.count", 32'(retireCount), 32'd3);

        // J without loop: retires in decode
        op = 2'b11; loopFlag = 1'b0;
        step(); check("j.branch", 32'(sigBranch), 32'd1); check("j.retire", 32'(retire), 32'd1);
        step(); check("j.count", 32'(retireCount), 32'd4);

        // drop run during EXEC of an ADD
        op = 2'b00;
        step(); step(); run = 1'b0;
        step(); check("stop.retire", 32'(retire), 32'd1);
        step(); check("stop.idle", 32'(state), 32'd0); check("stop.count", 32'(retireCount), 32'd5);
        check("stop.ctl", 32'({sigIRWrite, sigPCWrite, sigRegWrite}), 32'd0);

        // J with loopFlag: halt, run has no effect, reset exits
        run = 1'b1; op = 2'b11;
        step(); loopFlag = 1'b1;
        step(); check("loop.branch", 32'(sigBranch), 32'd1); check("loop.noret", 32'(retire), 32'd0);
        step(); check("loop.halt", 32'(state), 32'd6); check("loop.halted", 32'(halted), 32'd1);
        loopFlag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            step();
            check("loop.sticky", 32'(state), 32'd6);
        end
        reset = 1'b1; #1;
        check("loop.rst", 32'(state), 32'd0); check("loop.rsthalt", 32'(halted), 32'd0);
        step(); reset = 1'b0; run = 1'b1; op = 2'b00;
        check("loop.count0", 32'(retireCount), 32'd0);

        // reset during WB of the second ADD
        repeat (8) step();
        check("rwb.state", 32'(state), 32'd5); check("rwb.rw", 32'(sigRegWrite), 32'd1);
        check("rwb.cnt", 32'(retireCount), 32'd1);
        #2 reset = 1'b1; #1;
        check("rwb.rwdrop", 32'(sigRegWrite), 32'd0); check("rwb.pcdrop", 32'(sigPCWrite), 32'd0);
        check("rwb.count", 32'(retireCount), 32'd0); check("rwb.ret", 32'(retire), 32'd0);
        step(); reset = 1'b0; op = 2'b11; loopFlag = 1'b0; run = 1'b1;

        // 256 back-to-back J retires wrap the counter
        repeat (511) step();
        check("wrap.255", 32'(retireCount), 32'd255);
        step(); step();
        check("wrap.0", 32'(retireCount), 32'd0); check("wrap.state", 32'(state), 32'd1);

        // ADD with overflow in EXEC
        op = 2'b00;
        step(); step(); ovfFlag = 1'b1;
        step(); ovfFlag = 1'b0;
`ifdef MC_HALT_ON_OVF_EN
        check("ovf.halt", 32'(state), 32'd6); check("ovf.norw", 32'(sigRegWrite), 32'd0);
        check("ovf.noret", 32'(retire), 32'd0);
`else
        check("ovf.wb", 32'(state), 32'd5); check("ovf.rw", 32'(sigRegWrite), 32'd1);
        check("ovf.ret", 32'(retire), 32'd1);
`endif
        run = 1'b0;
        step(); step();
        reset = 1'b1;
        step(); step();
        check("end.state", 32'(state), 32'd0);
        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
